// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the writeback write queue.
// Holds default widths, the PC register index and the queue entry layout.
package wb_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    // Register index reserved for the program counter; never queued.
    localparam logic [3:0] PC_IDX = 4'hF;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wbq_storage.sv
// wbq_storage: entry array for the writeback queue.
// Two write ports (older/younger request), one combinational read port at the
// head, and a per-entry destination compare vector for the hazard checks.
// An entry's valid bit drops on the edge it is read out, so an entry sitting
// in the output register no longer shows up in the compare vectors.
module wbq_storage #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic [PTR_W-1:0]  waddr0,
    input  logic [ADDR_W-1:0] wdest0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [PTR_W-1:0]  waddr1,
    input  logic [ADDR_W-1:0] wdest1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              re,
    input  logic [PTR_W-1:0]  raddr,
    output logic [ADDR_W-1:0] rdest,
    output logic [DATA_W-1:0] rdata,
    input  logic [ADDR_W-1:0] chk_src1,
    input  logic [ADDR_W-1:0] chk_src2,
    output logic [DEPTH-1:0]  hit_vec1,
    output logic [DEPTH-1:0]  hit_vec2
);

    logic [DEPTH-1:0]  valid_r;
    logic [ADDR_W-1:0] dest_r [DEPTH];
    logic [DATA_W-1:0] data_r [DEPTH];

    // Entry array update: clear on read-out, then apply the two writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_r[i] <= '0;
                data_r[i] <= '0;
            end
        end else begin
            if (re) begin
                valid_r[raddr] <= 1'b0;
            end
            if (we0) begin
                valid_r[waddr0] <= 1'b1;
                dest_r[waddr0]  <= wdest0;
                data_r[waddr0]  <= wdata0;
            end
            if (we1) begin
                valid_r[waddr1] <= 1'b1;
                dest_r[waddr1]  <= wdest1;
                data_r[waddr1]  <= wdata1;
            end
        end
    end

    assign rdest = dest_r[raddr];
    assign rdata = data_r[raddr];

    // Per-entry match of queued destinations against the two ID-stage reads.
    always_comb begin
        hit_vec1 = '0;
        hit_vec2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec1[i] = valid_r[i] && (dest_r[i] == chk_src1);
            hit_vec2[i] = valid_r[i] && (dest_r[i] == chk_src2);
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue: queue in front of the register file's single write port.
// Accepts up to two writes per cycle (in0 older than in1), drains one per
// cycle in order into registered {writeBackEn, Dest_wb, Result_wb}, and flags
// queued destinations so ID can stall dependent reads. PC-targeted requests
// are dropped. in_ready is withheld at DEPTH-1 so a dual push always fits.
// Optional macro WBQ_BYPASS_EN: an accepted non-PC in0 arriving at an empty
// queue is loaded straight into the output register on the same edge.
module wb_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_valid,
    input  logic [ADDR_W-1:0] in0_dest,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in1_valid,
    input  logic [ADDR_W-1:0] in1_dest,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in_ready,
    output logic              writeBackEn,
    output logic [31:0]       Dest_wb,
    output logic [DATA_W-1:0] Result_wb,
    input  logic [ADDR_W-1:0] chk_src1,
    input  logic [ADDR_W-1:0] chk_src2,
    output logic              pend_hit1,
    output logic              pend_hit2,
    output logic [CNT_W-1:0]  count
);
    import wb_pkg::*;

    localparam logic [ADDR_W-1:0] PC_DEST = ADDR_W'(PC_IDX);

    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic              wb_en_r;
    logic [ADDR_W-1:0] wb_dest_r;
    logic [DATA_W-1:0] wb_data_r;

    logic              acc0_s;
    logic              acc1_s;
    logic              pop_s;
    logic              byp_s;
    logic              push0_s;
    logic              push1_s;
    logic [1:0]        n_push_s;
    logic [PTR_W-1:0]  waddr1_s;
    logic [ADDR_W-1:0] head_dest_s;
    logic [DATA_W-1:0] head_data_s;
    logic [DEPTH-1:0]  hit_vec1_s;
    logic [DEPTH-1:0]  hit_vec2_s;

    assign in_ready = (count_r <= CNT_W'(DEPTH - 2));

    // Accept/push/pop decode; pop uses pre-edge occupancy only.
    always_comb begin
        acc0_s = in_ready && in0_valid && (in0_dest != PC_DEST);
        acc1_s = in_ready && in1_valid && (in1_dest != PC_DEST);
        pop_s  = (count_r != '0);
`ifdef WBQ_BYPASS_EN
        byp_s  = acc0_s && (count_r == '0);
`else
        byp_s  = 1'b0;
`endif
        push0_s  = acc0_s && !byp_s;
        push1_s  = acc1_s;
        n_push_s = {1'b0, push0_s} + {1'b0, push1_s};
        if (push0_s) begin
            waddr1_s = tail_r + PTR_W'(1'b1);
        end else begin
            waddr1_s = tail_r;
        end
    end

    wbq_storage #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_storage (
        .clk      (clk),
        .rst      (rst),
        .we0      (push0_s),
        .waddr0   (tail_r),
        .wdest0   (in0_dest),
        .wdata0   (in0_data),
        .we1      (push1_s),
        .waddr1   (waddr1_s),
        .wdest1   (in1_dest),
        .wdata1   (in1_data),
        .re       (pop_s),
        .raddr    (head_r),
        .rdest    (head_dest_s),
        .rdata    (head_data_s),
        .chk_src1 (chk_src1),
        .chk_src2 (chk_src2),
        .hit_vec1 (hit_vec1_s),
        .hit_vec2 (hit_vec2_s)
    );

    // Pointer and occupancy update; pointers wrap modulo DEPTH naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            head_r  <= head_r + PTR_W'(pop_s);
            tail_r  <= tail_r + PTR_W'(n_push_s);
            count_r <= count_r + CNT_W'(n_push_s) - CNT_W'(pop_s);
        end
    end

    // Output register: head entry on pop, in0 on bypass, otherwise hold data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_r   <= 1'b0;
            wb_dest_r <= '0;
            wb_data_r <= '0;
        end else if (pop_s) begin
            wb_en_r   <= 1'b1;
            wb_dest_r <= head_dest_s;
            wb_data_r <= head_data_s;
        end else if (byp_s) begin
            wb_en_r   <= 1'b1;
            wb_dest_r <= in0_dest;
            wb_data_r <= in0_data;
        end else begin
            wb_en_r   <= 1'b0;
        end
    end

    assign writeBackEn = wb_en_r;
    assign Dest_wb     = {{(32 - ADDR_W){1'b0}}, wb_dest_r};
    assign Result_wb   = wb_data_r;
    assign count       = count_r;

    // A PC read index can never be pending: PC writes are never queued.
    assign pend_hit1 = (|hit_vec1_s) && (chk_src1 != PC_DEST);
    assign pend_hit2 = (|hit_vec2_s) && (chk_src2 != PC_DEST);

endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: directed self-checking bench for wb_write_queue
// (DEPTH=4). Expected values are hand-computed; the burst section uses a
// small in-order queue model. Honours WBQ_BYPASS_EN when it is defined.
module tb_wb_write_queue;

    localparam int DEPTH = 4;
`ifdef WBQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in0_valid;
    logic [3:0]  in0_dest;
    logic [31:0] in0_data;
    logic        in1_valid;
    logic [3:0]  in1_dest;
    logic [31:0] in1_data;
    logic        in_ready;
    logic        writeBackEn;
    logic [31:0] Dest_wb;
    logic [31:0] Result_wb;
    logic [3:0]  chk_src1;
    logic [3:0]  chk_src2;
    logic        pend_hit1;
    logic        pend_hit2;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    logic [31:0] regs [16];
    logic [35:0] exp_q [$];
    int          mc;
    logic        exp_en;
    logic [3:0]  exp_dest;
    logic [31:0] exp_data;
    logic        last_rdy;

    wb_write_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in0_valid   (in0_valid),
        .in0_dest    (in0_dest),
        .in0_data    (in0_data),
        .in1_valid   (in1_valid),
        .in1_dest    (in1_dest),
        .in1_data    (in1_data),
        .in_ready    (in_ready),
        .writeBackEn (writeBackEn),
        .Dest_wb     (Dest_wb),
        .Result_wb   (Result_wb),
        .chk_src1    (chk_src1),
        .chk_src2    (chk_src2),
        .pend_hit1   (pend_hit1),
        .pend_hit2   (pend_hit2),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Register file model: commits on the negedge after the output register loads.
    always @(negedge clk) begin
        if (writeBackEn) regs[Dest_wb[3:0]] <= Result_wb;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    // Queue model for one edge, evaluated on the inputs presented before it.
    task automatic model_edge;
        logic a0, a1, pop, byp;
        last_rdy = (mc <= DEPTH - 2);
        a0  = last_rdy && in0_valid && (in0_dest != 4'hF);
        a1  = last_rdy && in1_valid && (in1_dest != 4'hF);
        pop = (mc > 0);
        byp = BYP && (mc == 0) && a0;
        if (pop) begin
            {exp_dest, exp_data} = exp_q.pop_front();
            exp_en = 1'b1;
        end else if (byp) begin
            exp_dest = in0_dest;
            exp_data = in0_data;
            exp_en   = 1'b1;
        end else begin
            exp_en = 1'b0;
        end
        if (a0 && !byp) exp_q.push_back({in0_dest, in0_data});
        if (a1) exp_q.push_back({in1_dest, in1_data});
        mc = exp_q.size();
    endtask

    task automatic model_check(input string tag);
        chk({tag, "_en"}, 32'(writeBackEn), 32'(exp_en));
        if (exp_en) begin
            chk({tag, "_dest"}, Dest_wb, {28'd0, exp_dest});
            chk({tag, "_data"}, Result_wb, exp_data);
        end
        chk({tag, "_count"}, 32'(count), 32'(mc));
        chk({tag, "_ready"}, 32'(in_ready), 32'(mc <= DEPTH - 2));
    endtask

    initial begin
        int s;
        clk = 1'b0;
        rst = 1'b1;
        idle();
        in0_dest = 4'd0; in0_data = 32'd0;
        in1_dest = 4'd0; in1_data = 32'd0;
        chk_src1 = 4'd0; chk_src2 = 4'd0;
        for (int i = 0; i < 16; i++) regs[i] = 32'd0;

        // ---- reset then idle
        #1 rst = 1'b0;
        #2;
        chk("rst_en",    32'(writeBackEn), 32'd0);
        chk("rst_dest",  Dest_wb, 32'd0);
        chk("rst_data",  Result_wb, 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_pend",  32'({pend_hit1, pend_hit2}), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        tick(); tick();
        chk("idle_en",    32'(writeBackEn), 32'd0);
        chk("idle_count", 32'(count), 32'd0);

        // ---- single push in0 dest=3 data=A5
        in0_valid = 1'b1; in0_dest = 4'd3; in0_data = 32'hA5;
        chk_src1 = 4'd3;
        tick();
        idle();
        chk("single_n_en",    32'(writeBackEn), BYP ? 32'd1 : 32'd0);
        chk("single_n_count", 32'(count), BYP ? 32'd0 : 32'd1);
        chk("single_n_pend",  32'(pend_hit1), BYP ? 32'd0 : 32'd1);
        tick();
        chk("single_n1_en",   32'(writeBackEn), BYP ? 32'd0 : 32'd1);
        chk("single_dest",    Dest_wb, 32'd3);
        chk("single_data",    Result_wb, 32'hA5);
        chk("single_count",   32'(count), 32'd0);
        chk("single_pend",    32'(pend_hit1), 32'd0);
        @(negedge clk); #1;
        chk("single_reg3",    regs[3], 32'hA5);

        // ---- dual push, same dest 2: 7 then 9
        in0_valid = 1'b1; in0_dest = 4'd2; in0_data = 32'd7;
        in1_valid = 1'b1; in1_dest = 4'd2; in1_data = 32'd9;
        chk_src1 = 4'd2;
        tick();
        idle();
        chk("dual_n_count", 32'(count), BYP ? 32'd1 : 32'd2);
        chk("dual_n_ready", 32'(in_ready), 32'd1);
        chk("dual_n_pend",  32'(pend_hit1), 32'd1);
        chk("dual_n_en",    32'(writeBackEn), BYP ? 32'd1 : 32'd0);
        tick();
        chk("dual_n1_en",   32'(writeBackEn), 32'd1);
        chk("dual_n1_dest", Dest_wb, 32'd2);
        chk("dual_n1_data", Result_wb, BYP ? 32'd9 : 32'd7);
        chk("dual_n1_pend", 32'(pend_hit1), BYP ? 32'd0 : 32'd1);
        tick();
        chk("dual_n2_en",   32'(writeBackEn), BYP ? 32'd0 : 32'd1);
        chk("dual_n2_data", Result_wb, 32'd9);
        chk("dual_n2_pend", 32'(pend_hit1), 32'd0);
        chk("dual_n2_count", 32'(count), 32'd0);
        @(negedge clk); #1;
        chk("dual_reg2",    regs[2], 32'd9);

        // ---- PC filtering: in0 dest=15 dropped, in1 dest=5 kept
        in0_valid = 1'b1; in0_dest = 4'hF; in0_data = 32'hDEAD;
        in1_valid = 1'b1; in1_dest = 4'd5; in1_data = 32'd1;
        chk_src1 = 4'hF; chk_src2 = 4'd5;
        tick();
        idle();
        chk("pc_n_count", 32'(count), 32'd1);
        chk("pc_n_en",    32'(writeBackEn), 32'd0);
        chk("pc_pend1",   32'(pend_hit1), 32'd0);
        chk("pc_pend2",   32'(pend_hit2), 32'd1);
        tick();
        chk("pc_n1_en",   32'(writeBackEn), 32'd1);
        chk("pc_n1_dest", Dest_wb, 32'd5);
        chk("pc_n1_data", Result_wb, 32'd1);
        tick();
        chk("pc_n2_en",   32'(writeBackEn), 32'd0);
        @(negedge clk); #1;
        chk("pc_reg15",   regs[15], 32'd0);
        chk("pc_reg5",    regs[5], 32'd1);

        // ---- dual push every cycle, several pointer wraps
        mc = 0;
        exp_q.delete();
        s = 0;
        for (int c = 0; c < 20; c++) begin
            in0_valid = 1'b1; in0_dest = 4'(s % 15);       in0_data = 32'hB000_0000 + 32'(2 * s);
            in1_valid = 1'b1; in1_dest = 4'((s + 4) % 15); in1_data = 32'hB000_0001 + 32'(2 * s);
            model_edge();
            tick();
            model_check("burst");
            if (last_rdy) s++;
        end
        idle();
        for (int c = 0; c < 6; c++) begin
            model_edge();
            tick();
            model_check("drain");
        end

        // ---- asynchronous reset mid-burst with count=3
        chk_src1 = 4'd8;
        for (int c = 0; c < (BYP ? 3 : 2); c++) begin
            in0_valid = 1'b1; in0_dest = 4'd8; in0_data = 32'h80 + 32'(c);
            in1_valid = 1'b1; in1_dest = 4'd9; in1_data = 32'h90 + 32'(c);
            tick();
        end
        idle();
        chk("mid_count", 32'(count), 32'd3);
        chk("mid_ready", 32'(in_ready), 32'd0);
        chk("mid_pend",  32'(pend_hit1), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_en",    32'(writeBackEn), 32'd0);
        chk("arst_dest",  Dest_wb, 32'd0);
        chk("arst_data",  Result_wb, 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        chk("arst_pend",  32'(pend_hit1), 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("post_rst_en",    32'(writeBackEn), 32'd0);
            chk("post_rst_count", 32'(count), 32'd0);
        end
        in0_valid = 1'b1; in0_dest = 4'd6; in0_data = 32'h66;
        tick();
        idle();
        chk("post_push_n_en", 32'(writeBackEn), BYP ? 32'd1 : 32'd0);
        tick();
        chk("post_push_n1_en", 32'(writeBackEn), BYP ? 32'd0 : 32'd1);
        chk("post_push_dest",  Dest_wb, 32'd6);
        chk("post_push_data",  Result_wb, 32'h66);
        chk("post_push_count", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
